sdram_wr_seq: RTL

SDRAM_WR_SEQ -- requirements
Module: sdram_wr_seq

---
 rtl/sdram_wr_seq.sv | 118 +++++++++++
 1 files changed

// File: rtl/sdram_wr_seq.sv
// SDRAM write sequencer: turns burst requests plus a write-data stream into registered cmd/addr/data beats.
// Optional macro SDRAM_WR_SEQ_GAP_EN inserts a one-cycle GAP state between bursts.
module sdram_wr_seq #(
  parameter int DATA_SZ_P = 32,
  parameter int ADDR_SZ_P = 10,
  parameter int LEN_SZ_P  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 burst_valid,
  output logic                 burst_ready,
  input  logic [ADDR_SZ_P-1:0] burst_addr,
  input  logic [LEN_SZ_P-1:0]  burst_len,
  input  logic                 wdata_valid,
  output logic                 wdata_ready,
  input  logic [DATA_SZ_P-1:0] wdata,
  output logic                 cmd,
  output logic [ADDR_SZ_P-1:0] addr,
  output logic [DATA_SZ_P-1:0] data,
  output logic                 busy,
  output logic                 done
);

`ifdef SDRAM_WR_SEQ_GAP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, BURST = 2'd1, GAP = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, BURST = 2'd1} state_t;
`endif

  state_t                 state;
  state_t                 state_nxt;
  logic [ADDR_SZ_P-1:0]   cur_addr;
  logic [ADDR_SZ_P-1:0]   cur_addr_inc;
  logic [LEN_SZ_P-1:0]    len_lat;
  logic [LEN_SZ_P-1:0]    cnt;
  logic [LEN_SZ_P-1:0]    cnt_inc;
  logic                   burst_fire;
  logic                   beat_fire;
  logic                   last_beat;
  logic                   len_zero;

  assign burst_ready  = (state == IDLE);
  assign wdata_ready  = (state == BURST);
  assign busy         = (state != IDLE);
  assign burst_fire   = burst_valid & burst_ready;
  assign beat_fire    = wdata_valid & wdata_ready;
  assign len_zero     = (burst_len == {LEN_SZ_P{1'b0}});
  assign cnt_inc      = cnt + {{(LEN_SZ_P-1){1'b0}}, 1'b1};
  assign cur_addr_inc = cur_addr + {{(ADDR_SZ_P-1){1'b0}}, 1'b1};
  // The beat whose incremented count reaches the latched length is the last one.
  assign last_beat    = beat_fire & (cnt_inc == len_lat);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (burst_fire && !len_zero) begin
          state_nxt = BURST;
        end else begin
          state_nxt = IDLE;
        end
      end
      BURST: begin
        if (last_beat) begin
`ifdef SDRAM_WR_SEQ_GAP_EN
          state_nxt = GAP;
`else
          state_nxt = IDLE;
`endif
        end else begin
          state_nxt = BURST;
        end
      end
`ifdef SDRAM_WR_SEQ_GAP_EN
      GAP:     state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Burst bookkeeping and registered SDRAM beat outputs; addr/data hold between beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd      <= 1'b0;
      addr     <= {ADDR_SZ_P{1'b0}};
      data     <= {DATA_SZ_P{1'b0}};
      done     <= 1'b0;
      cur_addr <= {ADDR_SZ_P{1'b0}};
      len_lat  <= {LEN_SZ_P{1'b0}};
      cnt      <= {LEN_SZ_P{1'b0}};
    end else begin
      cmd  <= beat_fire;
      done <= (burst_fire & len_zero) | last_beat;
      if (burst_fire && !len_zero) begin
        cur_addr <= burst_addr;
        len_lat  <= burst_len;
        cnt      <= {LEN_SZ_P{1'b0}};
      end
      if (beat_fire) begin
        addr     <= cur_addr;
        data     <= wdata;
        cur_addr <= cur_addr_inc;
        cnt      <= cnt_inc;
      end
    end
  end

endmodule
